// File: rtl/pipeline_pkg.sv
// Shared instruction-field layout, opcode/ALU-op constants and multdiv FSM encoding
// for the pipeline hazard controller.
package pipeline_pkg;
    localparam int INS_W   = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 17;
    localparam int RT_MSB  = 16;
    localparam int RT_LSB  = 12;
    localparam int ALU_MSB = 6;
    localparam int ALU_LSB = 2;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] OPC_LW    = 5'b01000;
    localparam logic [4:0] OPC_SW    = 5'b00111;
    localparam logic [4:0] ALU_MULT  = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    localparam int              CNT_W   = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    function automatic logic f_is_md(input logic [4:0] opc, input logic [4:0] alu);
        return (opc == OPC_RTYPE) && ((alu == ALU_MULT) || (alu == ALU_DIV));
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a lw in D/X whose destination feeds the F/D instruction.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [INS_W-1:0] fd_ins,
    input  logic [INS_W-1:0] dx_ins,
    output logic             load_use
);
    logic [4:0] w_dx_rd;
    logic [4:0] w_fd_rs;
    logic [4:0] w_fd_rt;
    logic [4:0] w_fd_opc;
    logic       w_dx_lw;
    logic       w_fd_uses_rt;
    logic       w_unused;

    assign w_dx_rd  = dx_ins[RD_MSB:RD_LSB];
    assign w_fd_rs  = fd_ins[RS_MSB:RS_LSB];
    assign w_fd_rt  = fd_ins[RT_MSB:RT_LSB];
    assign w_fd_opc = fd_ins[OPC_MSB:OPC_LSB];
    assign w_dx_lw  = (dx_ins[OPC_MSB:OPC_LSB] == OPC_LW);

    // rt is only a source register for R-type and sw; elsewhere it holds immediate bits
    assign w_fd_uses_rt = (w_fd_opc == OPC_RTYPE) || (w_fd_opc == OPC_SW);

    assign load_use = w_dx_lw && (w_dx_rd != 5'd0) &&
                      ((w_dx_rd == w_fd_rs) || (w_fd_uses_rt && (w_dx_rd == w_fd_rt)));

    assign w_unused = ^{fd_ins[RD_MSB:RD_LSB], fd_ins[RT_LSB-1:0], dx_ins[RS_MSB:0]};
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: multdiv sequencing FSM with timeout plus load-use
// and branch hazard steering of the latch enables.
module pipeline_ctrl
    import pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [INS_W-1:0] fd_ins,
    input  logic [INS_W-1:0] dx_ins,
    input  logic             branch_taken,
    input  logic             md_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_bubble,
    output logic             md_ctrl_mult,
    output logic             md_ctrl_div,
    output logic             md_busy,
    output logic             md_timeout
);
    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_timeout;

    logic w_dx_md;
    logic w_load_use;
    logic w_busy;
    logic w_md_stall;
    logic w_stall;

    assign w_dx_md = f_is_md(dx_ins[OPC_MSB:OPC_LSB], dx_ins[ALU_MSB:ALU_LSB]);

    hazard_detect u_hazard (
        .fd_ins   (fd_ins),
        .dx_ins   (dx_ins),
        .load_use (w_load_use)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_dx_md) begin
                        r_state   <= ST_START;
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                        r_is_div  <= (dx_ins[ALU_MSB:ALU_LSB] == ALU_DIV);
                    end
                end
                ST_START: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (md_ready) begin
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state   <= ST_DONE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_busy     = (r_state == ST_START) || (r_state == ST_WAIT);
    assign w_md_stall = w_busy || ((r_state == ST_IDLE) && w_dx_md);
    assign w_stall    = w_md_stall | w_load_use;

    // A taken branch squashes the dependent consumer, so it may overrule a load-use stall
    assign pc_en     = ~w_stall | (branch_taken & ~w_md_stall);
    assign fd_en     = pc_en;
    assign dx_en     = ~w_md_stall;
    assign xm_bubble = w_md_stall;
    assign fd_flush  = branch_taken;
    assign dx_flush  = (w_load_use & ~w_md_stall) | branch_taken;

    assign md_busy      = w_busy;
    assign md_ctrl_mult = (r_state == ST_START) && !r_is_div;
    assign md_ctrl_div  = (r_state == ST_START) && r_is_div;
    assign md_timeout   = r_timeout;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; outputs are packed as
// {pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_bubble, md_ctrl_mult, md_ctrl_div, md_busy, md_timeout}.
module tb_pipeline_ctrl;
    logic        clk;
    logic        reset_n;
    logic [31:0] fd_ins;
    logic [31:0] dx_ins;
    logic        branch_taken;
    logic        md_ready;
    logic        pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_bubble;
    logic        md_ctrl_mult, md_ctrl_div, md_busy, md_timeout;

    int total;
    int bad;

    pipeline_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fd_ins       (fd_ins),
        .dx_ins       (dx_ins),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .dx_en        (dx_en),
        .fd_flush     (fd_flush),
        .dx_flush     (dx_flush),
        .xm_bubble    (xm_bubble),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_busy      (md_busy),
        .md_timeout   (md_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] opc, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {opc, rd, rs, rt, 12'd0};
    endfunction

    // Expected output patterns
    localparam logic [9:0] RUN      = 10'b1110000000;
    localparam logic [9:0] STALL_MD = 10'b0000010000;
    localparam logic [9:0] START_M  = 10'b0000011010;
    localparam logic [9:0] START_D  = 10'b0000010110;
    localparam logic [9:0] WAIT_E   = 10'b0000010010;
    localparam logic [9:0] LU       = 10'b0010100000;
    localparam logic [9:0] BR_LU    = 10'b1111100000;
    localparam logic [9:0] BR_MD    = 10'b0001110000;
    localparam logic [9:0] TO       = 10'b0000000001;

    logic [31:0] NOP, MULT, DIV, LW3, LW0, ADD_RS3, ADD_RT3, SW_RT3, ADDI_RT3, ADD_R0;

    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_bubble,
               md_ctrl_mult, md_ctrl_div, md_busy, md_timeout};
        total++;
        $display("chk %-16s obs=%b exp=%b", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input logic [31:0] fd, input logic [31:0] dx, input logic bt,
                        input logic rdy, input string tag, input logic [9:0] exp);
        fd_ins       = fd;
        dx_ins       = dx;
        branch_taken = bt;
        md_ready     = rdy;
        #1;
        chk(tag, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        NOP      = 32'd0;
        MULT     = r_ins(5'd1, 5'd2, 5'd3, 5'b00110);
        DIV      = r_ins(5'd4, 5'd5, 5'd6, 5'b00111);
        LW3      = i_ins(5'b01000, 5'd3, 5'd9, 5'd0);
        LW0      = i_ins(5'b01000, 5'd0, 5'd9, 5'd0);
        ADD_RS3  = r_ins(5'd5, 5'd3, 5'd4, 5'd0);
        ADD_RT3  = r_ins(5'd5, 5'd1, 5'd3, 5'd0);
        SW_RT3   = i_ins(5'b00111, 5'd0, 5'd1, 5'd3);
        ADDI_RT3 = i_ins(5'b00101, 5'd7, 5'd1, 5'd3);
        ADD_R0   = r_ins(5'd5, 5'd0, 5'd0, 5'd0);

        // Reset behaviour
        reset_n = 1'b0;
        fd_ins = NOP; dx_ins = NOP; branch_taken = 1'b0; md_ready = 1'b0;
        #2;
        chk("rst_idle", RUN);
        step(NOP, MULT, 1'b0, 1'b0, "rst_md_stall", STALL_MD);
        dx_ins = NOP;
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        step(NOP, NOP, 1'b0, 1'b0, "idle_nop", RUN);

        // Multiply, ready after 5 WAIT cycles
        cyc(); step(NOP, MULT, 1'b0, 1'b0, "mul_idle_stall", STALL_MD);
        cyc(); step(NOP, MULT, 1'b0, 1'b0, "mul_start", START_M);
        for (int i = 1; i <= 5; i++) begin
            cyc(); step(NOP, MULT, 1'b0, (i == 5), "mul_wait", WAIT_E);
        end
        cyc(); step(NOP, MULT, 1'b0, 1'b0, "mul_done", RUN);
        cyc(); step(NOP, NOP, 1'b0, 1'b0, "mul_back_idle", RUN);

        // Load-use hazards
        cyc(); step(ADD_RS3, LW3, 1'b0, 1'b0, "lu_rs", LU);
        cyc(); step(ADD_RS3, NOP, 1'b0, 1'b0, "lu_released", RUN);
        step(ADD_RT3, LW3, 1'b0, 1'b0, "lu_rt_rtype", LU);
        step(SW_RT3, LW3, 1'b0, 1'b0, "lu_rt_sw", LU);
        step(ADDI_RT3, LW3, 1'b0, 1'b0, "lu_rt_itype_no", RUN);
        step(ADD_R0, LW0, 1'b0, 1'b0, "lu_rd0_no", RUN);

        // Branch overrides load-use, but not a multdiv stall
        step(ADD_RS3, LW3, 1'b1, 1'b0, "br_over_lu", BR_LU);
        step(NOP, MULT, 1'b1, 1'b0, "br_md_stall", BR_MD);
        dx_ins = NOP; branch_taken = 1'b0;
        cyc(); step(NOP, NOP, 1'b0, 1'b0, "br_idle", RUN);

        // Divide that never completes: 64 WAIT cycles then timeout
        cyc(); step(NOP, DIV, 1'b0, 1'b0, "to_idle_stall", STALL_MD);
        cyc(); step(NOP, DIV, 1'b0, 1'b0, "to_start", START_D);
        for (int i = 0; i < 64; i++) begin
            cyc(); step(NOP, DIV, 1'b0, 1'b0, "to_wait", WAIT_E);
        end
        cyc(); step(NOP, DIV, 1'b0, 1'b0, "to_done", RUN | TO);
        cyc(); step(NOP, NOP, 1'b0, 1'b1, "to_sticky_idle", RUN | TO);
        cyc(); step(NOP, NOP, 1'b0, 1'b0, "to_rdy_idle_ign", RUN | TO);

        // Next divide clears timeout at START; ready during START is ignored
        step(NOP, DIV, 1'b0, 1'b0, "div2_idle", STALL_MD | TO);
        cyc(); step(NOP, DIV, 1'b0, 1'b1, "div2_start", START_D);
        cyc(); step(NOP, DIV, 1'b0, 1'b0, "div2_rdy_ign", WAIT_E);
        cyc(); step(NOP, DIV, 1'b0, 1'b1, "div2_wait", WAIT_E);
        cyc(); step(NOP, DIV, 1'b0, 1'b0, "div2_done", RUN);

        // Mult immediately followed by div
        cyc(); step(NOP, MULT, 1'b0, 1'b0, "md_mul_idle", STALL_MD);
        cyc(); step(NOP, MULT, 1'b0, 1'b0, "md_mul_start", START_M);
        cyc(); step(NOP, MULT, 1'b0, 1'b1, "md_mul_wait", WAIT_E);
        cyc(); step(NOP, MULT, 1'b0, 1'b0, "md_mul_done", RUN);
        cyc(); step(NOP, DIV, 1'b0, 1'b0, "md_div_idle", STALL_MD);
        cyc(); step(NOP, DIV, 1'b0, 1'b0, "md_div_start", START_D);
        cyc(); step(NOP, DIV, 1'b0, 1'b1, "md_div_wait", WAIT_E);
        cyc(); step(NOP, DIV, 1'b0, 1'b0, "md_div_done", RUN);
        cyc(); step(NOP, NOP, 1'b0, 1'b0, "md_idle", RUN);

        // Asynchronous reset in WAIT with counter at 20
        cyc(); step(NOP, MULT, 1'b0, 1'b0, "ar_idle", STALL_MD);
        cyc(); step(NOP, MULT, 1'b0, 1'b0, "ar_start", START_M);
        for (int i = 0; i <= 20; i++) begin
            cyc(); step(NOP, MULT, 1'b0, 1'b0, "ar_wait", WAIT_E);
        end
        #1 reset_n = 1'b0;
        #1 chk("ar_async_idle", STALL_MD);
        dx_ins = NOP;
        #1 chk("ar_rst_nop", RUN);
        cyc(); step(NOP, NOP, 1'b0, 1'b0, "ar_rst_held", RUN);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); step(NOP, NOP, 1'b0, 1'b0, "ar_no_pulse", RUN);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
